// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_pkg
//  Description : Shared game types and frame-rate constants for the Pac-Man
//                controller blocks. One frame equals one frame_clk cycle.
//                Contents:
//                  game_state_t - top-level game state
//                  dir_t        - movement direction encoding
//                  abs_diff10   - unsigned 10-bit absolute difference
//  Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        FRIGHT    = 3'd2,
        DYING     = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    localparam int c_FRIGHT_FRAMES  = 480;
    localparam int c_WARN_FRAMES    = 120;
    localparam int c_RESPAWN_FRAMES = 90;

    // Larger minus smaller, so the result never wraps.
    function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage : pacman_pkg
`default_nettype wire

// File: rtl/ghost_hit_detect.sv
`default_nettype none
// ============================================================================
//  Module      : ghost_hit_detect
//  Description : Combinational Pac-Man/ghost contact detection. A ghost is in
//                contact when both |dx| and |dy| between the tile centres are
//                strictly below HIT_DIST.
//  Ports       : PacX, PacY       - Pac-Man centre position
//                ghost_x, ghost_y - packed ghost centres, 10 bits per ghost
//                hit              - one contact bit per ghost
//  Revision    : 1.0 - initial release
// ============================================================================
module ghost_hit_detect
    import pacman_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int HIT_DIST   = 8
) (
    input  logic [9:0]              PacX,
    input  logic [9:0]              PacY,
    input  logic [NUM_GHOSTS*10-1:0] ghost_x,
    input  logic [NUM_GHOSTS*10-1:0] ghost_y,
    output logic [NUM_GHOSTS-1:0]   hit
);

    localparam logic [9:0] c_HIT = 10'(HIT_DIST);

    for (genvar i = 0; i < NUM_GHOSTS; i++) begin : g_ghost
        logic [9:0] w_dx;
        logic [9:0] w_dy;
        assign w_dx   = abs_diff10(PacX, ghost_x[i*10 +: 10]);
        assign w_dy   = abs_diff10(PacY, ghost_y[i*10 +: 10]);
        assign hit[i] = (w_dx < c_HIT) && (w_dy < c_HIT);
    end

endmodule : ghost_hit_detect
`default_nettype wire

// File: rtl/life_fright_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : life_fright_ctrl
//  Description : Game-state controller for Pac-Man. Tracks lives, frightened
//                mode after power pellets, ghost-eaten events, respawn delay
//                and game over. All outputs are registered.
//  Ports       : frame_clk    - frame clock (one cycle per frame)
//                Reset        - synchronous active-high reset
//                PacX, PacY   - Pac-Man centre position
//                hasMoved     - Pac-Man has stepped since spawn
//                ghost_x/y    - packed ghost centres
//                power_pellet - one-cycle pulse on pellet eaten
//                isDefeated   - life lost, Pac-Man held at spawn
//                death        - game over
//                reversal     - frightened mode active
//                fright_warn  - frightened mode ending soon
//                ghost_eaten  - per-ghost one-cycle eaten pulse
//                lives        - remaining lives
//  Revision    : 1.0 - initial release
// ============================================================================
module life_fright_ctrl
    import pacman_pkg::*;
#(
    parameter int NUM_GHOSTS     = 4,
    parameter int LIVES_INIT     = 3,
    parameter int FRIGHT_FRAMES  = c_FRIGHT_FRAMES,
    parameter int WARN_FRAMES    = c_WARN_FRAMES,
    parameter int RESPAWN_FRAMES = c_RESPAWN_FRAMES,
    parameter int HIT_DIST       = 8
) (
    input  logic                     frame_clk,
    input  logic                     Reset,
    input  logic [9:0]               PacX,
    input  logic [9:0]               PacY,
    input  logic                     hasMoved,
    input  logic [NUM_GHOSTS*10-1:0] ghost_x,
    input  logic [NUM_GHOSTS*10-1:0] ghost_y,
    input  logic                     power_pellet,
    output logic                     isDefeated,
    output logic                     death,
    output logic                     reversal,
    output logic                     fright_warn,
    output logic [NUM_GHOSTS-1:0]    ghost_eaten,
    output logic [1:0]               lives
);

    localparam int c_TMAX = (FRIGHT_FRAMES > RESPAWN_FRAMES) ? FRIGHT_FRAMES : RESPAWN_FRAMES;
    localparam int TW     = $clog2(c_TMAX + 1);

    localparam logic [TW-1:0] c_FRIGHT_LOAD  = TW'(FRIGHT_FRAMES - 1);
    localparam logic [TW-1:0] c_RESPAWN_LOAD = TW'(RESPAWN_FRAMES - 1);
    localparam logic [TW-1:0] c_WARN         = TW'(WARN_FRAMES);
    localparam logic [1:0]    c_LIVES        = 2'(LIVES_INIT);

    game_state_t           r_state;
    logic [TW-1:0]         r_timer;
    logic [NUM_GHOSTS-1:0] r_mask;
    logic                  r_defeated;
    logic                  r_death;
    logic                  r_reversal;
    logic                  r_warn;
    logic [NUM_GHOSTS-1:0] r_ghost_eaten;
    logic [1:0]            r_lives;

    logic [NUM_GHOSTS-1:0] w_hit;
    logic [NUM_GHOSTS-1:0] w_new_eat;
    logic                  w_any_hit;
    logic                  w_revived_hit;
    logic [TW-1:0]         w_timer_dec;

    ghost_hit_detect #(
        .NUM_GHOSTS (NUM_GHOSTS),
        .HIT_DIST   (HIT_DIST)
    ) u_hit (
        .PacX    (PacX),
        .PacY    (PacY),
        .ghost_x (ghost_x),
        .ghost_y (ghost_y),
        .hit     (w_hit)
    );

    assign w_any_hit     = |w_hit;
    assign w_new_eat     = w_hit & ~r_mask;
    // A ghost already eaten this fright has revived and is dangerous again.
    assign w_revived_hit = |(w_hit & r_mask);
    assign w_timer_dec   = r_timer - TW'(1);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_mask        <= '0;
            r_defeated    <= 1'b0;
            r_death       <= 1'b0;
            r_reversal    <= 1'b0;
            r_warn        <= 1'b0;
            r_ghost_eaten <= '0;
            r_lives       <= c_LIVES;
        end else begin
            r_ghost_eaten <= '0;
            case (r_state)
                IDLE: begin
                    if (hasMoved) begin
                        r_state <= PLAY;
                    end
                end

                PLAY: begin
                    // Pellet wins over a same-frame contact.
                    if (power_pellet) begin
                        r_state    <= FRIGHT;
                        r_timer    <= c_FRIGHT_LOAD;
                        r_mask     <= '0;
                        r_reversal <= 1'b1;
                        r_warn     <= (c_FRIGHT_LOAD < c_WARN);
                    end else if (w_any_hit) begin
                        r_state    <= DYING;
                        r_lives    <= r_lives - 2'd1;
                        r_timer    <= c_RESPAWN_LOAD;
                        r_defeated <= 1'b1;
                    end
                end

                FRIGHT: begin
                    if (w_revived_hit) begin
                        r_state    <= DYING;
                        r_lives    <= r_lives - 2'd1;
                        r_timer    <= c_RESPAWN_LOAD;
                        r_defeated <= 1'b1;
                        r_reversal <= 1'b0;
                        r_warn     <= 1'b0;
                        r_mask     <= '0;
                    end else begin
                        r_ghost_eaten <= w_new_eat;
                        if (power_pellet) begin
                            r_timer <= c_FRIGHT_LOAD;
                            r_mask  <= r_mask | w_new_eat;
                            r_warn  <= (c_FRIGHT_LOAD < c_WARN);
                        end else if (r_timer == '0) begin
                            r_state    <= PLAY;
                            r_mask     <= '0;
                            r_reversal <= 1'b0;
                            r_warn     <= 1'b0;
                        end else begin
                            r_timer <= w_timer_dec;
                            r_mask  <= r_mask | w_new_eat;
                            r_warn  <= (w_timer_dec < c_WARN);
                        end
                    end
                end

                DYING: begin
                    if (r_timer == '0) begin
                        r_defeated <= 1'b0;
                        if (r_lives == 2'd0) begin
                            r_state <= GAME_OVER;
                            r_death <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_timer <= w_timer_dec;
                    end
                end

                GAME_OVER: begin
                    r_death <= 1'b1;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign isDefeated  = r_defeated;
    assign death       = r_death;
    assign reversal    = r_reversal;
    assign fright_warn = r_warn;
    assign ghost_eaten = r_ghost_eaten;
    assign lives       = r_lives;

endmodule : life_fright_ctrl
`default_nettype wire

// File: tb/tb_life_fright_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_fright_ctrl
//  Description : Self-checking bench for life_fright_ctrl. A frame-level
//                reference model (frames-remaining counters) is stepped with
//                the same inputs as the DUT; directed steps check the
//                boundaries and durations, then a randomized phase runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_fright_ctrl;

    localparam int NG     = 4;
    localparam int LIVES  = 3;
    localparam int FRIGHT = 480;
    localparam int WARN   = 120;
    localparam int RESP   = 90;
    localparam int HIT    = 8;

    logic            frame_clk = 1'b0;
    logic            Reset;
    logic [9:0]      PacX, PacY;
    logic            hasMoved;
    logic [NG*10-1:0] ghost_x, ghost_y;
    logic            power_pellet;
    logic            isDefeated, death, reversal, fright_warn;
    logic [NG-1:0]   ghost_eaten;
    logic [1:0]      lives;

    always #5 frame_clk = ~frame_clk;

    life_fright_ctrl #(
        .NUM_GHOSTS     (NG),
        .LIVES_INIT     (LIVES),
        .FRIGHT_FRAMES  (FRIGHT),
        .WARN_FRAMES    (WARN),
        .RESPAWN_FRAMES (RESP),
        .HIT_DIST       (HIT)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .PacX         (PacX),
        .PacY         (PacY),
        .hasMoved     (hasMoved),
        .ghost_x      (ghost_x),
        .ghost_y      (ghost_y),
        .power_pellet (power_pellet),
        .isDefeated   (isDefeated),
        .death        (death),
        .reversal     (reversal),
        .fright_warn  (fright_warn),
        .ghost_eaten  (ghost_eaten),
        .lives        (lives)
    );

    // Reference model: frames remaining in each timed phase.
    int      m_lives, m_fright, m_respawn;
    bit      m_over, m_started;
    bit [3:0] m_mask, m_eat;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt, warn_cnt, warn_rise;

    function automatic bit [3:0] model_hits();
        bit [3:0] h = '0;
        for (int i = 0; i < NG; i++) begin
            int dx, dy;
            dx = int'(PacX) - int'(ghost_x[i*10 +: 10]);
            dy = int'(PacY) - int'(ghost_y[i*10 +: 10]);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            h[i] = (dx < HIT) && (dy < HIT);
        end
        return h;
    endfunction

    task automatic lose_life();
        m_lives   = m_lives - 1;
        m_respawn = RESP;
        m_fright  = 0;
        m_mask    = '0;
    endtask

    task automatic model_step();
        bit [3:0] h;
        h     = model_hits();
        m_eat = '0;
        if (Reset) begin
            m_lives = LIVES; m_fright = 0; m_respawn = 0;
            m_over = 0; m_started = 0; m_mask = '0;
        end else if (m_over) begin
            // frozen until reset
        end else if (m_respawn > 0) begin
            m_respawn = m_respawn - 1;
            if (m_respawn == 0) begin
                m_started = 0;
                if (m_lives == 0) m_over = 1;
            end
        end else if (!m_started) begin
            if (hasMoved) m_started = 1;
        end else if (m_fright > 0) begin
            if ((h & m_mask) != 0) begin
                lose_life();
            end else begin
                m_eat  = h & ~m_mask;
                m_mask = m_mask | m_eat;
                if (power_pellet) begin
                    m_fright = FRIGHT;
                end else begin
                    m_fright = m_fright - 1;
                    if (m_fright == 0) m_mask = '0;
                end
            end
        end else begin
            if (power_pellet) begin
                m_fright = FRIGHT;
                m_mask   = '0;
            end else if (h != 0) begin
                lose_life();
            end
        end
    endtask

    function automatic logic [31:0] model_out();
        logic [31:0] v;
        v = {22'd0, (m_respawn > 0), m_over, (m_fright > 0),
             (m_fright > 0 && m_fright <= WARN), m_eat, 2'(m_lives)};
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        model_step();
        #1;
        check("model", {22'd0, isDefeated, death, reversal, fright_warn, ghost_eaten, lives},
              model_out());
    endtask

    task automatic set_ghost(input int i, input int x, input int y);
        ghost_x[i*10 +: 10] = 10'(x);
        ghost_y[i*10 +: 10] = 10'(y);
    endtask

    task automatic ghosts_far();
        for (int i = 0; i < NG; i++) set_ghost(i, 600 + 60 * i, 900);
    endtask

    // Called with isDefeated already high; counts its high cycles.
    task automatic wait_respawn(input string tag);
        cnt = 1;
        for (int k = 0; k < 300 && isDefeated; k++) begin
            step();
            if (isDefeated) cnt++;
        end
        check(tag, cnt, RESP);
    endtask

    initial begin
        Reset = 1'b1; hasMoved = 1'b0; power_pellet = 1'b0;
        PacX = 10'd100; PacY = 10'd100;
        ghosts_far();
        step(); step();
        check("rst_lives", lives, LIVES);
        check("rst_flags", {isDefeated, death, reversal, fright_warn, ghost_eaten}, 0);

        Reset = 1'b0;
        step();
        hasMoved = 1'b1;
        step();

        // Boundary: dx = +8 no contact, +7 contact.
        set_ghost(0, 108, 100); step();
        check("dx8_nohit", isDefeated, 0);
        set_ghost(0, 107, 100); step();
        check("dx7_hit", isDefeated, 1);
        check("lives_after_hit", lives, 2);
        ghosts_far();
        wait_respawn("respawn_len_1");
        step();

        // Pac right of ghost, and dy boundary.
        set_ghost(0, 92, 100); step();
        check("dxm8_nohit", isDefeated, 0);
        set_ghost(0, 100, 108); step();
        check("dy8_nohit", isDefeated, 0);

        // Same-frame pellet and contact: fright wins, no life lost.
        set_ghost(0, 93, 100); power_pellet = 1'b1; step();
        power_pellet = 1'b0; ghosts_far();
        check("pellet_prio_rev", reversal, 1);
        check("pellet_prio_life", {isDefeated, lives}, {1'b0, 2'd2});

        cnt = 1; warn_cnt = 0; warn_rise = 0;
        for (int k = 0; k < 700 && reversal; k++) begin
            step();
            if (reversal) cnt++;
            if (fright_warn) warn_cnt++;
            if (fright_warn && warn_rise == 0) warn_rise = cnt;
        end
        check("fright_len", cnt, FRIGHT);
        check("warn_len", warn_cnt, WARN);
        check("warn_rise", warn_rise, FRIGHT - WARN + 1);

        // Reload with 11 frames left.
        power_pellet = 1'b1; step(); power_pellet = 1'b0;
        repeat (FRIGHT - 11) step();
        check("warn_before_reload", fright_warn, 1);
        power_pellet = 1'b1; step(); power_pellet = 1'b0;
        check("reload_warn_off", {reversal, fright_warn}, 2'b10);
        repeat (20) step();
        check("reload_still_rev", reversal, 1);

        // Eat ghost1, then touch it again once revived.
        set_ghost(1, 100, 100); step();
        check("eat_g1", ghost_eaten, 4'b0010);
        step();
        check("revived_hit", {isDefeated, reversal, fright_warn, ghost_eaten, lives},
              {1'b1, 1'b0, 1'b0, 4'b0000, 2'd1});
        ghosts_far();
        wait_respawn("respawn_len_2");

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            Reset        = (c % 700 == 0) || ($urandom_range(0, 399) == 0);
            hasMoved     = ($urandom_range(0, 7) != 0);
            power_pellet = ($urandom_range(0, 39) == 0);
            PacX = 10'($urandom_range(20, 1000));
            PacY = 10'($urandom_range(20, 1000));
            for (int i = 0; i < NG; i++) begin
                if ($urandom_range(0, 11) == 0)
                    set_ghost(i, int'(PacX) + int'($urandom_range(0, 20)) - 10,
                                 int'(PacY) + int'($urandom_range(0, 20)) - 10);
                else
                    set_ghost(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
            step();
        end

        // Three deaths from a fresh game.
        Reset = 1'b1; power_pellet = 1'b0; hasMoved = 1'b1;
        PacX = 10'd100; PacY = 10'd100; ghosts_far();
        step();
        Reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            step();
            set_ghost(2, 100, 103); step();
            check("death_hit", {isDefeated, lives}, {1'b1, 2'(2 - d)});
            ghosts_far();
            wait_respawn("respawn_len_go");
        end
        check("game_over", {isDefeated, death, reversal, fright_warn, lives},
              {1'b1 ^ 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
        set_ghost(0, 100, 100);
        for (int k = 0; k < 40; k++) begin
            power_pellet = (k % 5 == 0);
            step();
        end
        power_pellet = 1'b0; ghosts_far();
        check("game_over_hold", {death, reversal, lives}, {1'b1, 1'b0, 2'd0});

        // Reset in the middle of frightened mode.
        Reset = 1'b1; step(); Reset = 1'b0;
        step();
        power_pellet = 1'b1; step(); power_pellet = 1'b0;
        repeat (100) step();
        check("midfright_rev", reversal, 1);
        Reset = 1'b1; step();
        check("rst_midfright_flags", {isDefeated, death, reversal, fright_warn, ghost_eaten}, 0);
        check("rst_midfright_lives", lives, LIVES);
        Reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_life_fright_ctrl
`default_nettype wire

// File: doc/life_fright_ctrl.md
Name: life_fright_ctrl

Overview:
- Game-state controller driving the pacman movement block's `isDefeated`, `death` and `reversal` inputs.
- Detects Pac-Man/ghost contact from tile-centre positions.
- Handles power-pellet frightened mode, ghost-eaten events, life loss with a respawn delay, and game over.
- Clocked by the frame clock; sits directly upstream of the pacman block and alongside the ghost blocks.

Parameters:
- `NUM_GHOSTS`, 4: number of ghosts checked for contact.
- `LIVES_INIT`, 3: lives after reset (1..3).
- `FRIGHT_FRAMES`, 480: frightened duration in frames.
- `WARN_FRAMES`, 120: final frightened frames during which `fright_warn` is asserted.
- `RESPAWN_FRAMES`, 90: frames `isDefeated` is held after a life is lost.
- `HIT_DIST`, 8: contact when both |dx| and |dy| are strictly less than this.

Ports:
- `frame_clk`  in  1  only clock; one cycle = one frame.
- `Reset`  in  1  synchronous, active-high.
- `PacX`, `PacY`  in  10 each  Pac-Man centre position (BallX/BallY).
- `hasMoved`  in  1  Pac-Man has taken its first step since spawn.
- `ghost_x`, `ghost_y`  in  NUM_GHOSTS x 10 each  ghost centre positions, packed.
- `power_pellet`  in  1  one-cycle pulse when a power pellet is eaten.
- `isDefeated`  out  1  life lost; Pac-Man held at spawn.
- `death`  out  1  game over; Pac-Man frozen.
- `reversal`  out  1  frightened mode active.
- `fright_warn`  out  1  frightened mode is ending soon (ghost flashing).
- `ghost_eaten`  out  NUM_GHOSTS  one-cycle pulse per ghost eaten; that ghost returns home.
- `lives`  out  2  remaining lives.

Behaviour:
- One clock (`frame_clk`). Reset is synchronous and active-high (`Reset`).
- Reset values: state IDLE; `lives` = LIVES_INIT; `isDefeated`, `death`, `reversal`, `fright_warn`, `ghost_eaten` all 0; timer 0; eaten mask 0.
- Reset mid-operation (any state, any timer value) restores these values on the next edge.
- All outputs are registered. An input sampled at edge n affects outputs from edge n onward; no extra latency.
- Contact detection (combinational):
  - `hit[i]` = (|PacX - ghost_x[i]| < HIT_DIST) && (|PacY - ghost_y[i]| < HIT_DIST).
  - Absolute difference is computed by comparing the operands and subtracting the smaller from the larger, unsigned 10-bit. No wrap.
- State IDLE:
  - All flags 0.
  - Go to PLAY when `hasMoved` = 1.
  - Contact and pellets are ignored in IDLE.
- State PLAY:
  - If `power_pellet`: go to FRIGHT, load timer = FRIGHT_FRAMES-1, clear eaten mask. This takes priority over any `hit` in the same cycle.
  - Else if any `hit`: go to DYING, `lives` <= `lives` - 1, timer = RESPAWN_FRAMES-1, `isDefeated` <= 1.
- State FRIGHT:
  - `reversal` = 1.
  - `fright_warn` = 1 while timer < WARN_FRAMES.
  - Each cycle, the timer decrements.
  - `power_pellet` reloads timer = FRIGHT_FRAMES-1; eaten mask is kept.
  - For each i with `hit[i]` and mask[i] = 0: pulse `ghost_eaten[i]` for 1 cycle and set mask[i]. Multiple ghosts in one cycle all pulse.
  - If `hit[i]` with mask[i] = 1 (ghost revived, no longer frightened): same as the PLAY death path, with `reversal` and `fright_warn` cleared on the same edge.
  - Timer = 0 with no pellet: go to PLAY, `reversal` <= 0, `fright_warn` <= 0, mask cleared.
- State DYING:
  - `isDefeated` = 1; `reversal` forced to 0 so the pacman block respawns.
  - Timer counts down. At 0: `isDefeated` <= 0.
  - If `lives` == 0, go to GAME_OVER; else go to IDLE. The pacman block clears `hasMoved` during `isDefeated`.
  - `hit` and `power_pellet` are ignored.
- State GAME_OVER:
  - `death` = 1, all other flags 0.
  - Held until `Reset`.
- `lives` never underflows: decrements only on DYING entry, and DYING entry with `lives` = 0 is unreachable.

Decomposition:
- Shared package `pacman_pkg`:
  - `game_state_t` enum {IDLE, PLAY, FRIGHT, DYING, GAME_OVER}.
  - Frame-rate constants (FRIGHT_FRAMES, WARN_FRAMES, RESPAWN_FRAMES defaults).
  - Direction encoding 0=right, 1=down, 2=left, 3=up.
- Sub-module `ghost_hit_detect`: parameterised by NUM_GHOSTS and HIT_DIST; purely combinational; outputs the `hit` vector.
- Timer and FSM stay in the top module.

Test Plan:
- Reset, then `hasMoved`=1 -> PLAY next cycle. Ghost0 placed at (PacX+7, PacY) -> `isDefeated`=1, `lives`=2, held exactly 90 cycles, then IDLE.
- Ghost0 at dx=8 -> no hit; dx=7 -> hit (boundary). Repeat with PacX < ghost_x to check the absolute difference.
- `power_pellet` pulse -> `reversal`=1 for exactly 480 cycles; `fright_warn` rises at timer=119. Ghost1 contact -> `ghost_eaten`=4'b0010 for one cycle; a second contact with ghost1 -> DYING with `reversal` cleared.
- Same-cycle `power_pellet` and hit in PLAY -> FRIGHT, no life lost. Pellet at timer=10 -> timer reloads to 479.
- Three deaths from LIVES_INIT=3 -> after the third respawn delay `death`=1, `lives`=0, stays until `Reset`. `Reset` asserted mid-FRIGHT -> all outputs 0, `lives`=3 on the next edge.
